// File: rtl/karatsuba_seq_mul_if.sv
// Handshake and operand/result bundle for karatsuba_seq_mul.
//   start, a, b, signed_mode : request side (master drives)
//   busy, done, product      : status/result side (slave drives)
interface karatsuba_seq_mul_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   signed_mode;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, product
    );
endinterface

// File: rtl/karatsuba_seq_mul.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier using one-level Karatsuba.
// The three half-width sub-products (a0*b0, a1*b1, (a1+a0)*(b1+b0)) run in
// sequence on one shared (H+1)-bit shift-add engine, one multiplier bit per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start/a/b/signed_mode : request, sampled only in IDLE
//   bus.busy   : high in every state except IDLE
//   bus.done   : one-cycle pulse, product valid
//   bus.product: result register, held until the next operation completes
module karatsuba_seq_mul #(
    parameter int unsigned WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    karatsuba_seq_mul_if.slave bus
);
    localparam int unsigned H   = WIDTH / 2;
    localparam int unsigned HP1 = H + 1;
    localparam int unsigned ZW  = 2 * H + 2;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned CW  = $clog2(HP1 + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PREP, S_MUL_Z0, S_MUL_Z2, S_MUL_Z1,
        S_COMB1, S_COMB2, S_FIX, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              sm_q, sm_d, neg_q, neg_d;
    logic [HP1-1:0]    sa_q, sa_d, sb_q, sb_d;
    logic [ZW-1:0]     mcand_q, mcand_d;
    logic [HP1-1:0]    mplier_q, mplier_d;
    logic [ZW-1:0]     eng_q, eng_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ZW-1:0]     z0_q, z0_d, z2_q, z2_d, z1_q, z1_d, m_q, m_d;
    logic [PW-1:0]     acc_q, acc_d, product_q, product_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [ZW-1:0]     eng_sum;
    logic [PW-1:0]     acc_fix;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sm_d      = sm_q;
        neg_d     = neg_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        eng_d     = eng_q;
        cnt_d     = cnt_q;
        z0_d      = z0_q;
        z2_d      = z2_q;
        z1_d      = z1_q;
        m_d       = m_q;
        acc_d     = acc_q;
        product_d = product_q;

        // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
        a_mag   = (sm_q && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
        b_mag   = (sm_q && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
        eng_sum = eng_q + (mplier_q[0] ? mcand_q : ZW'(0));
        acc_fix = neg_q ? (~acc_q + PW'(1)) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sm_d    = bus.signed_mode;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                a_d      = a_mag;
                b_d      = b_mag;
                neg_d    = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                sa_d     = HP1'(a_mag[WIDTH-1:H]) + HP1'(a_mag[H-1:0]);
                sb_d     = HP1'(b_mag[WIDTH-1:H]) + HP1'(b_mag[H-1:0]);
                mcand_d  = ZW'(a_mag[H-1:0]);
                mplier_d = HP1'(b_mag[H-1:0]);
                eng_d    = '0;
                cnt_d    = '0;
                state_d  = S_MUL_Z0;
            end
            S_MUL_Z0, S_MUL_Z2, S_MUL_Z1: begin
                eng_d    = eng_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last multiplier bit: capture the sub-product and preload the next one
                if (cnt_q == CW'(H)) begin
                    cnt_d = '0;
                    eng_d = '0;
                    if (state_q == S_MUL_Z0) begin
                        z0_d     = eng_sum;
                        mcand_d  = ZW'(a_q[WIDTH-1:H]);
                        mplier_d = HP1'(b_q[WIDTH-1:H]);
                        state_d  = S_MUL_Z2;
                    end else if (state_q == S_MUL_Z2) begin
                        z2_d     = eng_sum;
                        mcand_d  = ZW'(sa_q);
                        mplier_d = sb_q;
                        state_d  = S_MUL_Z1;
                    end else begin
                        z1_d     = eng_sum;
                        state_d  = S_COMB1;
                    end
                end
            end
            S_COMB1: begin
                m_d     = z1_q - z2_q - z0_q;
                state_d = S_COMB2;
            end
            S_COMB2: begin
                acc_d   = (PW'(z2_q) << (2 * H)) + (PW'(m_q) << H) + PW'(z0_q);
                state_d = S_FIX;
            end
            S_FIX: begin
                acc_d     = acc_fix;
                product_d = acc_fix;
                state_d   = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sm_q      <= 1'b0;
            neg_q     <= 1'b0;
            sa_q      <= '0;
            sb_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            eng_q     <= '0;
            cnt_q     <= '0;
            z0_q      <= '0;
            z2_q      <= '0;
            z1_q      <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sm_q      <= sm_d;
            neg_q     <= neg_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            eng_q     <= eng_d;
            cnt_q     <= cnt_d;
            z0_q      <= z0_d;
            z2_q      <= z2_d;
            z1_q      <= z1_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule
